// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter that shares the async FIFO write port
// among NREQ requesters, with per-source enables and a per-grant burst cap.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                     wclk,
    input  logic                     wrst_n,
    input  logic [NREQ-1:0]          cfg_en_i,
    input  logic [NREQ-1:0]          req_valid_i,
    input  logic [NREQ-1:0]          req_last_i,
    input  logic [NREQ*DATA_W-1:0]   req_data_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic                     wfull_i,
    output logic                     wincr_o,
    output logic [DATA_W-1:0]        wdata_o,
    output logic [NREQ-1:0]          grant_o,
    output logic                     busy_o,
    output logic                     burst_cut_o
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               burst_cut_q, burst_cut_d;

    logic [NREQ-1:0]    elig_s;
    logic [NREQ-1:0]    pick_s;
    logic [IDX_W-1:0]   owner_idx_s;
    logic [IDX_W-1:0]   next_ptr_s;
    logic               busy_s;
    logic               xfer_s;
    logic               owner_last_s;
    logic               cap_hit_s;
    logic [DATA_W-1:0]  wdata_s;

    // First set bit of elig at or above ptr, wrapping past NREQ-1 back to 0.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0]  elig,
                                                input logic [IDX_W-1:0] ptr);
        logic [NREQ-1:0] pick;
        logic            found;
        logic [IDX_W:0]  sum;
        logic [IDX_W-1:0] idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NREQ)) begin
                sum = sum - (IDX_W+1)'(NREQ);
            end else begin
                sum = sum;
            end
            idx = sum[IDX_W-1:0];
            if (!found && elig[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Owner index, next round-robin pointer and granted data slice.
    always_comb begin
        owner_idx_s = '0;
        wdata_s     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_q[k]) begin
                owner_idx_s = IDX_W'(k);
            end else begin
                owner_idx_s = owner_idx_s;
            end
            wdata_s = wdata_s | ({DATA_W{grant_q[k]}} & req_data_i[k*DATA_W +: DATA_W]);
        end
        if (owner_idx_s == LAST_IDX) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = owner_idx_s + IDX_W'(1);
        end
    end

    assign busy_s       = (state_q == ST_BUSY);
    assign elig_s       = req_valid_i & cfg_en_i;
    assign pick_s       = rr_pick(elig_s, rr_ptr_q);
    assign xfer_s       = busy_s & (|(grant_q & req_valid_i)) & ~wfull_i;
    assign owner_last_s = |(grant_q & req_valid_i & req_last_i);
    assign cap_hit_s    = (beat_cnt_q == CAP_CNT);

    // Next-state logic: grant in IDLE, count beats and release in BUSY.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_cut_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig_s != '0) begin
                    grant_d    = pick_s;
                    beat_cnt_d = '0;
                    state_d    = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (xfer_s) begin
                    if (owner_last_s || cap_hit_s) begin
                        state_d     = ST_IDLE;
                        grant_d     = '0;
                        rr_ptr_d    = next_ptr_s;
                        beat_cnt_d  = '0;
                        // A last beat that coincides with the cap is a normal end.
                        burst_cut_d = ~owner_last_s;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and grant registers.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            burst_cut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cut_q <= burst_cut_d;
        end
    end

    assign req_ready_o = grant_q & {NREQ{busy_s & ~wfull_i}};
    assign wincr_o     = xfer_s;
    assign wdata_o     = wdata_s;
    assign grant_o     = grant_q;
    assign busy_o      = busy_s;
    assign burst_cut_o = burst_cut_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a cycle table for short sequences, then queued
// requester sources with a per-requester scoreboard for longer scenarios.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              wclk;
    logic              wrst_n;
    logic [NREQ-1:0]   cfg_en_i;
    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_last_i;
    logic [NREQ*DW-1:0] req_data_i;
    logic [NREQ-1:0]   req_ready_o;
    logic              wfull_i;
    logic              wincr_o;
    logic [DW-1:0]     wdata_o;
    logic [NREQ-1:0]   grant_o;
    logic              busy_o;
    logic              burst_cut_o;

    fifo_wr_arbiter #(.NREQ(NREQ), .DATA_W(DW), .MAX_BURST(16)) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .cfg_en_i    (cfg_en_i),
        .req_valid_i (req_valid_i),
        .req_last_i  (req_last_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .wfull_i     (wfull_i),
        .wincr_o     (wincr_o),
        .wdata_o     (wdata_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .burst_cut_o (burst_cut_o)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int fails  = 0;

    function automatic void chk(string name, int unsigned act, int unsigned exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- table vectors ----------------
    typedef struct packed {
        logic [3:0] en;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       full;
        logic [3:0] g;
        logic       w;
        logic       b;
        logic [3:0] rdy;
    } vec_t;

    vec_t tv [17];

    // ---------------- source / scoreboard state ----------------
    logic [8:0]  src_q [NREQ][$];
    logic [7:0]  exp_q [NREQ][$];
    logic [5:0]  seq   [NREQ];
    int          grant_log[$];
    int          wr_log[$];
    logic [3:0]  cur_en;
    logic [3:0]  prev_grant;
    int          wr_cnt, cut_cnt, full_seen, full_cnt;
    bit          full_trig, full_chk;

    task automatic load_pkt(input int id, input int n, input bit with_last);
        logic [7:0] d;
        logic       l;
        for (int b = 0; b < n; b++) begin
            d = {id[1:0], seq[id]};
            seq[id] = seq[id] + 6'd1;
            l = with_last && (b == n - 1);
            src_q[id].push_back({l, d});
            exp_q[id].push_back(d);
        end
    endtask

    task automatic drive_src();
        cfg_en_i = cur_en;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid_i[i] = 1'b1;
                {req_last_i[i], req_data_i[i*DW +: DW]} = src_q[i][0];
            end else begin
                req_valid_i[i] = 1'b0;
                req_last_i[i]  = 1'b0;
                req_data_i[i*DW +: DW] = 8'h00;
            end
        end
        wfull_i = (full_cnt > 0);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        wr_log.delete();
        wr_cnt = 0; cut_cnt = 0; full_seen = 0;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
        return r;
    endfunction

    // One clock: drive, sample at negedge, pop accepted beats after the edge.
    task automatic tick();
        logic [NREQ-1:0] acc;
        int id;
        drive_src();
        @(negedge wclk);
        acc = req_valid_i & req_ready_o;
        if (wincr_o) begin
            id = int'(wdata_o[7:6]);
            chk("wr_owner", grant_o, 1 << id);
            if (exp_q[id].size() == 0) begin
                chk("sb_extra_beat", 1, 0);
            end else begin
                chk("sb_data", wdata_o, exp_q[id].pop_front());
            end
            wr_log.push_back(id);
            wr_cnt++;
        end
        if (grant_o != 4'h0 && grant_o != prev_grant) begin
            chk("idle_gap", prev_grant, 0);
            grant_log.push_back(onehot_idx(grant_o));
        end
        if (burst_cut_o) begin
            cut_cnt++;
            chk("cut_idle", busy_o, 0);
        end
        if (wfull_i && full_chk) begin
            full_seen++;
            chk("full_wincr", wincr_o, 0);
            chk("full_ready", req_ready_o, 0);
            chk("full_grant", grant_o, 4'b0010);
        end
        prev_grant = grant_o;
        @(posedge wclk);
        #1;
        for (int i = 0; i < NREQ; i++) if (acc[i]) void'(src_q[i].pop_front());
        if (full_cnt > 0) full_cnt--;
        if (full_trig && wr_cnt == 3) begin
            full_cnt  = 5;
            full_trig = 1'b0;
        end
    endtask

    function automatic bit pending(input logic [3:0] mask);
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (mask[i] && src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_until(input logic [3:0] mask, input int budget, input string name);
        int n = 0;
        while (pending(mask) && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, pending(mask), 0);
        repeat (3) tick();
    endtask

    task automatic run_until_wr(input int target, input int budget);
        int n = 0;
        while (wr_cnt < target && n < budget) begin
            tick();
            n++;
        end
        chk("wr_wait_timeout", (wr_cnt >= target) ? 1 : 0, 1);
    endtask

    initial begin
        int exp5b [6] = '{2, 3, 0, 2, 3, 0};
        int mm, cnt;
        logic [3:0] eg;
        for (int i = 0; i < NREQ; i++) seq[i] = 6'd0;
        cur_en = 4'hF; prev_grant = 4'h0; full_cnt = 0;
        full_trig = 1'b0; full_chk = 1'b0;
        clear_logs();

        //            en     vld    lst    full  grant  wincr busy  ready
        tv[0]  = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[1]  = '{4'hF, 4'h1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[2]  = '{4'hF, 4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 4'h1};
        tv[3]  = '{4'hF, 4'h1, 4'h0, 1'b0, 4'h1, 1'b1, 1'b1, 4'h1};
        tv[4]  = '{4'hF, 4'h1, 4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 4'h1};
        tv[5]  = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[6]  = '{4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[7]  = '{4'h0, 4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[8]  = '{4'hF, 4'h9, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[9]  = '{4'hF, 4'h9, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 4'h8};
        tv[10] = '{4'hF, 4'h9, 4'h9, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[11] = '{4'hF, 4'h9, 4'h9, 1'b1, 4'h1, 1'b0, 1'b1, 4'h0};
        tv[12] = '{4'hF, 4'h9, 4'h9, 1'b0, 4'h1, 1'b1, 1'b1, 4'h1};
        tv[13] = '{4'hF, 4'h9, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};
        tv[14] = '{4'hF, 4'h1, 4'h0, 1'b0, 4'h8, 1'b0, 1'b1, 4'h8};
        tv[15] = '{4'h7, 4'h8, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1, 4'h8};
        tv[16] = '{4'hF, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0};

        // Reset state, with requests pending and a clock edge inside reset.
        wrst_n = 1'b0; cfg_en_i = 4'hF; req_valid_i = 4'hF; req_last_i = 4'h0;
        req_data_i = 32'h0403_0201; wfull_i = 1'b0;
        #2;
        chk("rst_grant", grant_o, 0);
        chk("rst_wincr", wincr_o, 0);
        chk("rst_busy",  busy_o,  0);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_cut",   burst_cut_o, 0);
        #9;
        chk("rst_hold_grant", grant_o, 0);
        req_valid_i = 4'h0;
        #1 wrst_n = 1'b1;
        @(posedge wclk); #1;

        // Table: single-requester packet, disabled sources, rr wrap, full, stall.
        for (int r = 0; r < 17; r++) begin
            logic [3:0] rn;
            rn = 4'(r);
            cfg_en_i = tv[r].en; req_valid_i = tv[r].vld;
            req_last_i = tv[r].lst; wfull_i = tv[r].full;
            for (int i = 0; i < NREQ; i++) req_data_i[i*DW +: DW] = {4'(i), rn};
            eg = tv[r].g;
            @(negedge wclk);
            chk($sformatf("tv%0d_grant", r), grant_o, eg);
            chk($sformatf("tv%0d_wincr", r), wincr_o, tv[r].w);
            chk($sformatf("tv%0d_busy", r),  busy_o,  tv[r].b);
            chk($sformatf("tv%0d_ready", r), req_ready_o, tv[r].rdy);
            chk($sformatf("tv%0d_cut", r),   burst_cut_o, 0);
            chk($sformatf("tv%0d_wdata", r), wdata_o,
                (eg == 4'h0) ? 0 : {4'(onehot_idx(eg)), rn});
            @(posedge wclk); #1;
        end

        // Round robin among four continuous 1-beat requesters.
        clear_logs();
        for (int k = 0; k < 3; k++) for (int i = 0; i < NREQ; i++) load_pkt(i, 1, 1'b1);
        run_until(4'hF, 200, "rr");
        chk("rr_count", grant_log.size(), 12);
        mm = 0;
        for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != k % 4) mm++;
        chk("rr_order", mm, 0);

        // 8-beat packet with the FIFO full for 5 cycles after beat 3.
        clear_logs();
        full_trig = 1'b1; full_chk = 1'b1;
        load_pkt(1, 8, 1'b1);
        run_until(4'h2, 100, "full");
        full_chk = 1'b0;
        chk("full_cycles", full_seen, 5);
        chk("full_beats", wr_cnt, 8);
        chk("full_exp_left", exp_q[1].size(), 0);
        chk("full_grants", grant_log.size(), 1);

        // Burst cap: 20 beats from req2 with req3 waiting.
        clear_logs();
        load_pkt(2, 20, 1'b1);
        load_pkt(3, 1, 1'b1);
        run_until(4'hC, 200, "cap");
        chk("cap_cut_cnt", cut_cnt, 1);
        chk("cap_wr_cnt", wr_log.size(), 21);
        mm = 0;
        for (int k = 0; k < wr_log.size(); k++)
            if (wr_log[k] != ((k == 16) ? 3 : 2)) mm++;
        chk("cap_wr_order", mm, 0);
        chk("cap_grants", grant_log.size(), 3);
        if (grant_log.size() == 3) begin
            chk("cap_g0", grant_log[0], 2);
            chk("cap_g1", grant_log[1], 3);
            chk("cap_g2", grant_log[2], 2);
        end

        // Last and cap on the same beat: normal end, no cut pulse.
        clear_logs();
        load_pkt(0, 16, 1'b1);
        run_until(4'h1, 100, "lastcap");
        chk("lastcap_cut", cut_cnt, 0);
        chk("lastcap_wr", wr_cnt, 16);
        chk("lastcap_grants", grant_log.size(), 1);

        // Enable mask 1101: req1 is never granted.
        clear_logs();
        cur_en = 4'b1101;
        for (int k = 0; k < 2; k++) for (int i = 0; i < NREQ; i++) load_pkt(i, 1, 1'b1);
        run_until(4'hD, 200, "en_mask");
        chk("en_mask_count", grant_log.size(), 6);
        mm = 0;
        for (int k = 0; k < grant_log.size() && k < 6; k++) if (grant_log[k] != exp5b[k]) mm++;
        chk("en_mask_order", mm, 0);
        src_q[1].delete(); exp_q[1].delete();

        // Owner's enable cleared mid-packet: packet completes, no new grant.
        clear_logs();
        load_pkt(0, 6, 1'b1);
        run_until_wr(2, 50);
        cur_en = 4'b1100;
        load_pkt(0, 2, 1'b1);
        load_pkt(2, 1, 1'b1);
        repeat (40) tick();
        cnt = 0;
        for (int k = 0; k < wr_log.size(); k++) if (wr_log[k] == 0) cnt++;
        chk("enclr_req0_beats", cnt, 6);
        chk("enclr_req0_left", exp_q[0].size(), 2);
        chk("enclr_req2_left", exp_q[2].size(), 0);
        cnt = 0;
        for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] == 0) cnt++;
        chk("enclr_req0_grants", cnt, 1);
        src_q[0].delete(); exp_q[0].delete();

        // Asynchronous reset mid-packet, then rr pointer back to req0.
        clear_logs();
        cur_en = 4'hF;
        load_pkt(2, 10, 1'b1);
        run_until_wr(3, 50);
        #3 wrst_n = 1'b0;
        #1;
        chk("arst_wincr", wincr_o, 0);
        chk("arst_grant", grant_o, 0);
        chk("arst_busy",  busy_o,  0);
        chk("arst_ready", req_ready_o, 0);
        for (int i = 0; i < NREQ; i++) begin
            src_q[i].delete(); exp_q[i].delete();
        end
        for (int i = 0; i < NREQ; i++) load_pkt(i, 1, 1'b1);
        #10;
        drive_src();
        wrst_n = 1'b1;
        @(posedge wclk); #1;
        prev_grant = 4'h0;
        clear_logs();
        run_until(4'hF, 100, "post_rst");
        chk("post_rst_grants", grant_log.size(), 4);
        if (grant_log.size() > 0) chk("post_rst_first", grant_log[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
